// File: rtl/itermdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: function codes and FSM state type.
// FUNC_MADD/FUNC_MSUB are accepted only when ITERMDU_MADD_EN is defined.
package itermdu_pkg;

  localparam int W_FUNC = 3;

  localparam logic [W_FUNC-1:0] FUNC_MUL  = 3'd0;
  localparam logic [W_FUNC-1:0] FUNC_DIV  = 3'd1;
  localparam logic [W_FUNC-1:0] FUNC_MADD = 3'd2;
  localparam logic [W_FUNC-1:0] FUNC_MSUB = 3'd3;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDiv,
    StFix,
    StDone
  } itermdu_state_t;

  function automatic logic func_valid(input logic [W_FUNC-1:0] f);
`ifdef ITERMDU_MADD_EN
    return (f == FUNC_MUL) || (f == FUNC_DIV) || (f == FUNC_MADD) || (f == FUNC_MSUB);
`else
    return (f == FUNC_MUL) || (f == FUNC_DIV);
`endif
  endfunction

endpackage

// File: rtl/itermdu_divstep.sv
// One combinational restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference when it does not borrow.
module itermdu_divstep #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q
);

  always_comb begin
    q = (rem_in >= {1'b0, divisor});
    // A kept difference is always below the divisor, so it fits in WIDTH bits.
    rem_out = q ? (rem_in[WIDTH-1:0] - divisor) : rem_in[WIDTH-1:0];
  end

endmodule

// File: rtl/itermdu.sv
// Iterative multiply/divide unit with busy/done handshake and registered {hi, lo} result.
// Define ITERMDU_MADD_EN to enable multiply-accumulate/subtract against {hi_in, lo_in}.
module itermdu
  import itermdu_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [W_FUNC-1:0] func,
  input  logic              sign,
  input  logic [WIDTH-1:0]  source_a,
  input  logic [WIDTH-1:0]  source_b,
  input  logic [WIDTH-1:0]  hi_in,
  input  logic [WIDTH-1:0]  lo_in,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = WIDTH + MUL_STEP;
  localparam logic [CW-1:0] KMul = CW'(WIDTH / MUL_STEP);
  localparam logic [CW-1:0] KDiv = CW'(WIDTH);

  itermdu_state_t state, state_next;

  logic [WIDTH-1:0]   a_mag, a_raw, b_mag;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;
  logic [CW-1:0]      cnt;
  logic               neg_res, neg_rem, div_zero;
  logic [W_FUNC-1:0]  func_q;

  logic               accept, is_div;
  logic [WIDTH-1:0]   abs_a, abs_b;

  assign accept = start && func_valid(func) && ((state == StIdle) || (state == StDone));
  assign is_div = (func == FUNC_DIV);
  assign abs_a  = (sign && source_a[WIDTH-1]) ? -source_a : source_a;
  assign abs_b  = (sign && source_b[WIDTH-1]) ? -source_b : source_b;

  // Multiply step: add multiplicand times the low MUL_STEP multiplier bits, shift right.
  logic [MUL_STEP-1:0]         digit;
  logic [PW-1:0]               partial, sum;
  logic [2*WIDTH+MUL_STEP-1:0] wide;
  logic [2*WIDTH-1:0]          acc_mul;

  always_comb begin
    digit   = acc[MUL_STEP-1:0];
    partial = PW'(a_mag) * PW'(digit);
    sum     = PW'(acc[2*WIDTH-1:WIDTH]) + partial;
    wide    = {sum, acc[WIDTH-1:0]};
    acc_mul = wide[2*WIDTH+MUL_STEP-1:MUL_STEP];
  end

  // Divide step: dividend bits shift out of acc's low word, quotient bits shift in.
  logic [WIDTH-1:0]   rem_div;
  logic               qbit;
  logic [2*WIDTH-1:0] acc_div;

  itermdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_in  ({rem, acc[WIDTH-1]}),
    .divisor (b_mag),
    .rem_out (rem_div),
    .q       (qbit)
  );

  assign acc_div = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], qbit};

  logic [2*WIDTH-1:0] prod, res_mul;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    prod = neg_res ? -acc : acc;
`ifdef ITERMDU_MADD_EN
    if (func_q == FUNC_MADD) begin
      res_mul = {hi_in, lo_in} + prod;
    end else if (func_q == FUNC_MSUB) begin
      res_mul = {hi_in, lo_in} - prod;
    end else begin
      res_mul = prod;
    end
`else
    res_mul = prod;
`endif
    if (func_q != FUNC_DIV) begin
      {res_hi, res_lo} = res_mul;
    end else if (div_zero) begin
      res_hi = a_raw;
      res_lo = '1;
    end else begin
      res_hi = neg_rem ? -rem : rem;
      res_lo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end
  end

`ifndef ITERMDU_MADD_EN
  logic unused_acc_in;
  assign unused_acc_in = ^{hi_in, lo_in};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= StIdle;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      StIdle, StDone: state_next = accept ? (is_div ? StDiv : StMul) : StIdle;
      StMul, StDiv:   if (cnt == CW'(1)) state_next = StFix;
      StFix:          state_next = StDone;
      default:        state_next = StIdle;
    endcase
    if (flush) state_next = StIdle;
  end

  always_comb begin
    busy = (state == StMul) || (state == StDiv) || (state == StFix);
    done = (state == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_mag    <= '0;
      a_raw    <= '0;
      b_mag    <= '0;
      acc      <= '0;
      rem      <= '0;
      cnt      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      func_q   <= '0;
      hi       <= '0;
      lo       <= '0;
    end else if (accept && !flush) begin
      a_mag    <= abs_a;
      a_raw    <= source_a;
      b_mag    <= abs_b;
      acc      <= {{WIDTH{1'b0}}, is_div ? abs_a : abs_b};
      rem      <= '0;
      cnt      <= is_div ? KDiv : KMul;
      neg_res  <= sign && (source_a[WIDTH-1] ^ source_b[WIDTH-1]);
      neg_rem  <= sign && source_a[WIDTH-1];
      div_zero <= (source_b == '0);
      func_q   <= func;
    end else if (state == StMul) begin
      acc <= acc_mul;
      cnt <= cnt - CW'(1);
    end else if (state == StDiv) begin
      acc <= acc_div;
      rem <= rem_div;
      cnt <= cnt - CW'(1);
    end else if ((state == StFix) && !flush) begin
      hi <= res_hi;
      lo <= res_lo;
    end
  end

endmodule

// File: doc/itermdu.md
# itermdu

Iterative, parametrised multiply/divide unit for the EX stage. It replaces the fixed-function HI/LO multiply/divide path with a multi-cycle engine that takes operands and `func`/sign from the ALU decode. It holds a busy/done handshake toward pipeline control and writes a {hi, lo} result pair. Width and multiply radix are generic. Flush cancels an operation in flight.

## Interface
Parameters:
- `WIDTH`, 32, operand width; even, ≥ 8
- `MUL_STEP`, 1, multiplier bits retired per cycle; power of two dividing `WIDTH`

Ports:
- `clk` in 1: clock, rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `start` in 1: request; sampled only in IDLE or DONE
- `func` in `W_FUNC`: `FUNC_MUL`, `FUNC_DIV` (plus `FUNC_MADD`/`FUNC_MSUB` when configured); any other value leaves `start` ignored
- `sign` in 1: 1 = signed operation
- `source_a` in WIDTH: multiplicand / dividend
- `source_b` in WIDTH: multiplier / divisor
- `hi_in` in WIDTH: accumulator high word (MADD/MSUB)
- `lo_in` in WIDTH: accumulator low word (MADD/MSUB)
- `flush` in 1: abort the current operation
- `busy` out 1: high in MUL, DIV and FIX states
- `done` out 1: one-cycle pulse; `hi`/`lo` valid in that cycle
- `hi` out WIDTH: product[2W-1:W] / remainder; registered, holds until next `done`
- `lo` out WIDTH: product[W-1:0] / quotient; registered, holds until next `done`

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- Accept: a valid `start` in IDLE or DONE latches the operand magnitudes (two's-complement abs when `sign`=1), the result-sign flags and `func`.
  - Next state is MUL or DIV.
  - The iteration counter is loaded with K. K = WIDTH/MUL_STEP for MUL. K = WIDTH for DIV.
- MUL: shift-add, MUL_STEP multiplier bits per cycle into a 2·WIDTH accumulator. After K cycles, go to FIX.
- DIV: restoring division, one quotient bit per cycle, WIDTH+1-bit partial remainder. After K cycles, go to FIX.
- FIX: apply signs, then register `hi`/`lo`, then go to DONE.
  - Product is negated over 2·WIDTH if sign(a)^sign(b).
  - Quotient is negated if sign(a)^sign(b).
  - Remainder takes the sign of the dividend.
- DONE: `done`=1 for one cycle. Go to IDLE, or to MUL/DIV if a new valid `start` arrives.
- Divide by zero: no trap, same latency. Result is `lo`=all-ones and `hi`=`source_a`, regardless of `sign`.
- Signed INT_MIN / -1: `lo`=INT_MIN, `hi`=0. No overflow flag.
- `start` in MUL/DIV/FIX is ignored. Requesters must stall on `busy`.
- `flush`: from any state, the next state is IDLE. `done` is not raised and `hi`/`lo` keep their previous values. `flush` wins over a simultaneous `start`.
- Reset (also mid-operation): state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0.

## Timing
- `start` accepted at edge 0. `busy` is high in cycles 1..K+1. `done` is high in cycle K+2.
- Latency = K+2: MUL is WIDTH/MUL_STEP+2 and DIV is WIDTH+2. At WIDTH=32: MUL_STEP=1 gives 34, MUL_STEP=4 gives 10, DIV gives 34.
- Back-to-back: `start` during DONE begins the next operation. `done` pulses exactly K+2 cycles apart.
- `hi_in`/`lo_in` are sampled in the FIX cycle, not at `start`. This lets the forwarded HI/LO settle.

## Configuration
- `ITERMDU_MADD_EN` defined: `FUNC_MADD`/`FUNC_MSUB` are accepted and run the MUL path.
  - In FIX, {hi,lo} = {hi_in,lo_in} ± signed/unsigned product, modulo 2^(2·WIDTH).
  - Latency is the same as MUL.
- Macro undefined: those `func` codes are ignored like any other unsupported code. `hi_in`/`lo_in` are unused.

## Structure
- Shared package `includes` holds:
  - the `itermdu_state_t` enum (IDLE, MUL, DIV, FIX, DONE)
  - the new `FUNC_MADD`/`FUNC_MSUB` codes, alongside the existing `W_FUNC`/`FUNC_*` definitions
- Sub-module `itermdu_divstep`: one combinational restoring-division step. Input is partial remainder and divisor; output is the next remainder and quotient bit.
- All state, counter and accumulator registers stay in `itermdu`.

## Test plan
- Unsigned MUL, WIDTH=32, MUL_STEP=1: a=0xFFFFFFFF, b=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. `done` exactly 34 cycles after `start`.
- Signed MUL, MUL_STEP=4: a=-3, b=7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. `done` at +10.
- Signed DIV: a=-7, b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Unsigned 5/0 → `lo`=0xFFFFFFFF, `hi`=5, at +34.
- `flush` 10 cycles into a DIV: `busy`=0 next cycle, no `done`, `hi`/`lo` unchanged. A `start` on the following cycle completes normally.
- Back-to-back: `start` MUL during DONE of a previous DIV → second `done` K+2 cycles later. `start` while `busy` is ignored. `rst_n`=0 mid-MUL → all outputs 0 next cycle.
- With `ITERMDU_MADD_EN`: {hi_in,lo_in}={0,0xFFFFFFFF}, MADD 1×1 → `hi`=1, `lo`=0. MSUB 1×1 from {0,0} → `hi`=`lo`=0xFFFFFFFF.
